// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Constants and types shared by the instruction-memory loader and the
// instruction memory itself.
//   IM_BASE_ADDR   : byte address of the first instruction word
//   IM_DEPTH       : instruction memory capacity in 32-bit words
//   loader_state_t : loader FSM states (IDLE, LOAD, DONE)
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
    localparam int          IM_DEPTH     = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage : mips_pkg

// File: rtl/im_loader_if.sv
// -----------------------------------------------------------------------------
// im_loader_if
// Bundles the loader's two buses: the incoming byte stream (valid/ready) and
// the instruction-memory write port.
//   in_valid / in_data : byte source -> loader
//   in_ready           : loader -> byte source
//   im_we / im_addr / im_wdata : loader -> instruction memory write port
// Modports:
//   master : the environment (byte source plus memory side)
//   slave  : the loader
// -----------------------------------------------------------------------------
interface im_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

endinterface : im_loader_if

// File: rtl/im_loader_packer.sv
// -----------------------------------------------------------------------------
// im_loader_packer
// Byte-to-word assembler. Bytes arrive MSB first; the fourth byte of a group
// completes the word {b0,b1,b2,b3}.
//   clk, reset     : clock, synchronous active-high reset
//   i_clear        : drop any partial word (new load starting)
//   i_valid        : a byte transfers this cycle
//   i_byte         : the byte
//   o_word         : assembled word, meaningful when o_word_valid is high
//   o_word_valid   : this cycle's byte completes a word
// The word outputs are combinational so the parent can register the memory
// write on the same edge that accepts the fourth byte.
// -----------------------------------------------------------------------------
module im_loader_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    // The three held bytes plus the byte on the bus form the complete word.
    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_valid && (r_cnt == 2'd3);

endmodule : im_loader_packer

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
// Boot-time instruction-memory writer. Accepts a byte stream, assembles
// big-endian 32-bit words and writes word k to BASE_ADDR + 4*k. Holds the CPU
// off via busy until the image is resident.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start, len     : load request and word count (sampled in IDLE/DONE only)
//   bus            : im_loader_if.slave (byte stream in, memory write out)
//   busy           : high while loading
//   done, err      : sticky completion / error flags
//   words_loaded   : words written in the current or last load
// Build option:
//   IM_LOADER_CHECKSUM_EN : expect a 4-byte trailer after the data words that
//                           must equal the modulo-2^32 sum of the words.
// -----------------------------------------------------------------------------
module im_loader
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
    parameter int          DEPTH     = IM_DEPTH,
    parameter int          LEN_W     = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    im_loader_if.slave       bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_loaded
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W:0]   ONE_G   = (LEN_W+1)'(1);

    loader_state_t    r_state;
    logic             r_in_ready;
    logic             r_im_we;
    logic [31:0]      r_im_addr;
    logic [31:0]      r_im_wdata;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W:0]   r_groups;         // 4-byte groups accepted (trailer included)
    logic [LEN_W-1:0] r_words_loaded;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0]      r_sum;
`endif

    logic             w_xfer;
    logic             w_start_acc;
    logic [31:0]      w_word;
    logic             w_word_valid;
    logic [LEN_W:0]   w_target;
    logic             w_is_data;
    logic             w_last_group;

    assign w_xfer      = bus.in_valid && r_in_ready;
    assign w_start_acc = start && (r_state != LOAD);

`ifdef IM_LOADER_CHECKSUM_EN
    assign w_target = {1'b0, r_len} + ONE_G;
`else
    assign w_target = {1'b0, r_len};
`endif
    assign w_is_data    = r_groups < {1'b0, r_len};
    assign w_last_group = (r_groups + ONE_G) == w_target;

    im_loader_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_acc),
        .i_valid      (w_xfer),
        .i_byte       (bus.in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_in_ready     <= 1'b0;
            r_im_we        <= 1'b0;
            r_im_addr      <= BASE_ADDR;
            r_im_wdata     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_len          <= '0;
            r_groups       <= '0;
            r_words_loaded <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum          <= '0;
`endif
        end else begin
            r_im_we <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_words_loaded <= '0;
                        r_groups       <= '0;
                        if (len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                        end else if (len > DEPTH_L) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state    <= LOAD;
                            r_busy     <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_done     <= 1'b0;
                            r_err      <= 1'b0;
                            r_len      <= len;
`ifdef IM_LOADER_CHECKSUM_EN
                            r_sum      <= '0;
`endif
                        end
                    end
                end

                LOAD: begin
                    if (w_word_valid) begin
                        r_groups <= r_groups + ONE_G;
                        // Stop accepting on the edge that takes the final byte,
                        // so no byte of a following image is swallowed.
                        if (w_last_group) begin
                            r_in_ready <= 1'b0;
                        end
                        if (w_is_data) begin
                            r_im_we        <= 1'b1;
                            r_im_addr      <= BASE_ADDR + 32'({r_groups, 2'b00});
                            r_im_wdata     <= w_word;
                            r_words_loaded <= r_words_loaded + LEN_W'(1);
`ifdef IM_LOADER_CHECKSUM_EN
                            r_sum          <= r_sum + w_word;
`endif
                        end
`ifdef IM_LOADER_CHECKSUM_EN
                        else begin
                            // Trailer word: compared, never written.
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_err   <= (r_sum != w_word);
                        end
`endif
                    end
`ifdef IM_LOADER_CHECKSUM_EN
`else
                    // Finish one cycle after the final write strobe.
                    if (r_im_we && (r_words_loaded == r_len)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
`endif
                end

                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.im_we     = r_im_we;
    assign bus.im_addr   = r_im_addr;
    assign bus.im_wdata  = r_im_wdata;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign words_loaded  = r_words_loaded;

endmodule : im_loader

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader
// Self-checking bench for im_loader. Expected memory writes are derived from
// the byte stream itself: word k = {b[4k],b[4k+1],b[4k+2],b[4k+3]} written at
// 0x3000 + 4k, strobed the cycle after its fourth byte is accepted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_im_loader;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          LEN_W = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] words_loaded;

    im_loader_if bus_if();

    im_loader #(
        .BASE_ADDR (BASE),
        .DEPTH     (4096),
        .LEN_W     (LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .bus          (bus_if),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;
    int          ready_drop;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned stamp;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    int unsigned done_rise = 0;
    logic        done_q    = 1'b0;
    logic [7:0]  stream[$];
    int unsigned acc[$];

    // Write monitor: every strobe observed, stamped with the edge that produced it.
    always @(negedge clk) begin
        if (bus_if.im_we) wr_q.push_back('{cyc, bus_if.im_addr, bus_if.im_wdata});
        if (done && !done_q) done_rise <= cyc;
        done_q <= done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return {stream[4*k], stream[4*k+1], stream[4*k+2], stream[4*k+3]};
    endfunction

    task automatic fill_random(input int n);
        stream.delete();
        for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    // Trailer = modulo-2^32 sum of the data words, plus a deliberate offset.
    task automatic append_trailer(input int n, input logic [31:0] offset);
        logic [31:0] s;
        s = offset;
        for (int k = 0; k < n; k++) s = s + exp_word(k);
        push_word(s);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, bus_if.in_ready, 0);
        check({tag, "_im_we"},    bus_if.im_we,    0);
        check({tag, "_busy"},     busy,            0);
        check({tag, "_done"},     done,            0);
        check({tag, "_err"},      err,             0);
        check({tag, "_im_addr"},  bus_if.im_addr,  BASE);
        check({tag, "_im_wdata"}, bus_if.im_wdata, 0);
        check({tag, "_words"},    words_loaded,    0);
    endtask

    // Drive stream[0..count-1]; called at a falling edge, returns at one.
    task automatic drive_bytes(input int count, input int gap_pct, input bit inject_start);
        int idx      = 0;
        int budget   = 0;
        bit injected = 1'b0;
        while (idx < count && budget < 4000) begin
            start = 1'b0;
            if (inject_start && !injected && idx >= 3) begin
                start    = 1'b1;
                len      = LEN_W'(1);
                injected = 1'b1;
            end
            if ($urandom_range(0, 99) >= gap_pct) begin
                bus_if.in_valid = 1'b1;
                bus_if.in_data  = stream[idx];
                if (bus_if.in_ready) begin
                    acc.push_back(cyc + 1);
                    idx++;
                end else begin
                    ready_drop++;
                end
            end else begin
                bus_if.in_valid = 1'b0;
                bus_if.in_data  = 8'($urandom);
            end
            @(negedge clk);
            budget++;
        end
        bus_if.in_valid = 1'b0;
        start           = 1'b0;
        if (idx < count) check("drive_timeout", idx, count);
    endtask

    task automatic do_load(input int n, input int gap_pct, input bit inject_start,
                           input bit exp_err, input string tag);
        int b = 0;
        int last;
        wr_q.delete();
        acc.delete();
        ready_drop = 0;
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_done"}, done, 0);
        check({tag, "_start_err"},  err,  0);
        drive_bytes(stream.size(), gap_pct, inject_start);
        while (!done && b < 50) begin
            @(negedge clk);
            b++;
        end
        check({tag, "_done"}, done, 1);
        repeat (3) @(negedge clk);
        check({tag, "_nwrites"}, wr_q.size(), n);
        for (int k = 0; k < n && k < wr_q.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), wr_q[k].addr, BASE + 32'(4*k));
            check($sformatf("%s_data%0d", tag, k), wr_q[k].data, exp_word(k));
            if (4*k+3 < acc.size())
                check($sformatf("%s_stamp%0d", tag, k), wr_q[k].stamp, acc[4*k+3]);
        end
        last = acc.size() - 1;
        if (last >= 0) begin
`ifdef IM_LOADER_CHECKSUM_EN
            check({tag, "_done_time"}, done_rise, acc[last]);
`else
            check({tag, "_done_time"}, done_rise, acc[last] + 1);
`endif
        end
        check({tag, "_ready_hold"}, ready_drop,      0);
        check({tag, "_words"},      words_loaded,    n);
        check({tag, "_err"},        err,             exp_err);
        check({tag, "_busy_end"},   busy,            0);
        check({tag, "_ready_end"},  bus_if.in_ready, 0);
    endtask

    // Requests that finish without loading anything.
    task automatic do_trivial(input int n, input bit exp_err, input string tag);
        wr_q.delete();
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done"},  done,            1);
        check({tag, "_err"},   err,             exp_err);
        check({tag, "_busy"},  busy,            0);
        check({tag, "_ready"}, bus_if.in_ready, 0);
        repeat (4) @(negedge clk);
        check({tag, "_nwrites"}, wr_q.size(), 0);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        len             = '0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("rst");

        // len==0 straight out of reset: done rises, no error, no writes.
        do_trivial(0, 1'b0, "len0");

        // Directed image, back-to-back bytes.
        stream.delete();
        push_word(32'h3C08_1234);
        push_word(32'h2409_0005);
`ifdef IM_LOADER_CHECKSUM_EN
        append_trailer(2, 32'd0);
`endif
        do_load(2, 0, 1'b0, 1'b0, "dir2");

        // Three words with random in_valid gaps.
        fill_random(3);
`ifdef IM_LOADER_CHECKSUM_EN
        append_trailer(3, 32'd0);
`endif
        do_load(3, 40, 1'b0, 1'b0, "gap3");

        // Oversized request: error, no writes.
        do_trivial(4097, 1'b1, "len4097");

        // A start from DONE clears err and restarts at the base address;
        // a start pulsed mid-load is ignored.
        fill_random(2);
`ifdef IM_LOADER_CHECKSUM_EN
        append_trailer(2, 32'd0);
`endif
        do_load(2, 20, 1'b1, 1'b0, "restart");

        for (int i = 0; i < 5; i++) begin
            int n;
            n = $urandom_range(1, 6);
            fill_random(n);
`ifdef IM_LOADER_CHECKSUM_EN
            append_trailer(n, 32'd0);
`endif
            do_load(n, $urandom_range(0, 60), 1'b0, 1'b0, $sformatf("rnd%0d", i));
        end

        // Reset after 6 of 8 bytes: one write done, partial word dropped.
        fill_random(2);
        wr_q.delete();
        acc.delete();
        ready_drop = 0;
        start = 1'b1;
        len   = LEN_W'(2);
        @(negedge clk);
        start = 1'b0;
        drive_bytes(6, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("midrst_nwrites", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            check("midrst_addr", wr_q[0].addr, BASE);
            check("midrst_data", wr_q[0].data, exp_word(0));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midrst");
        fill_random(1);
`ifdef IM_LOADER_CHECKSUM_EN
        append_trailer(1, 32'd0);
`endif
        do_load(1, 0, 1'b0, 1'b0, "after_rst");

`ifdef IM_LOADER_CHECKSUM_EN
        stream.delete();
        push_word(32'h0000_0001);
        push_word(32'h0000_0002);
        push_word(32'h0000_0003);
        do_load(2, 0, 1'b0, 1'b0, "csum_ok");
        stream.delete();
        push_word(32'h0000_0001);
        push_word(32'h0000_0002);
        push_word(32'h0000_0004);
        do_load(2, 30, 1'b0, 1'b1, "csum_bad");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_im_loader
